// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MUL  = 2'b01,
      OP_DIVU = 2'b10,
      OP_NONE = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   function automatic logic op_is_valid(input logic [1:0] op);
      return op_e'(op) != OP_NONE;
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if #(
   parameter int WIDTH = 24
);
   logic                 start;
   logic [1:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 write_hi;
   logic                 write_lo;
   logic [WIDTH-1:0]     write_data;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;
   logic [2*WIDTH-1:0]   read_data;

   modport master (
      output start, op, a, b, write_hi, write_lo, write_data,
      input  busy, done, hi, lo, read_data
   );

   modport slave (
      input  start, op, a, b, write_hi, write_lo, write_data,
      output busy, done, hi, lo, read_data
   );
endinterface

// File: rtl/mdu_hilo_reg.sv
// Double-width HI/LO result register; a finished operation outranks direct half writes.
module mdu_hilo_reg #(
   parameter int WIDTH = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_load,
   input  logic [2*WIDTH-1:0]   i_result,
   input  logic                 i_wr_hi,
   input  logic                 i_wr_lo,
   input  logic [WIDTH-1:0]     i_wr_data,
   output logic [WIDTH-1:0]     o_hi,
   output logic [WIDTH-1:0]     o_lo,
   output logic [2*WIDTH-1:0]   o_read_data
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (i_load) begin
         r_hi <= i_result[2*WIDTH-1:WIDTH];
         r_lo <= i_result[WIDTH-1:0];
      end else begin
         if (i_wr_hi) r_hi <= i_wr_data;
         if (i_wr_lo) r_lo <= i_wr_data;
      end
   end

   assign o_hi        = r_hi;
   assign o_lo        = r_lo;
   assign o_read_data = {r_hi, r_lo};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, WIDTH+1 cycle latency.
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic   i_clk,
   input  logic   i_rst,
   mdu_if.slave   io_mdu
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_e               r_state;
   state_e               w_state_next;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_sign;
   op_e                  r_op;

   op_e                  w_op;
   logic                 w_start_ok;
   logic                 w_accept;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_last;
   logic                 w_load;
   logic                 w_wr_hi;
   logic                 w_wr_lo;

   logic [WIDTH-1:0]     w_a_abs;
   logic [WIDTH-1:0]     w_b_abs;
   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_mul_next;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH+1:0]     w_diff;
   logic                 w_ge;
   logic [2*WIDTH-1:0]   w_div_next;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [2*WIDTH-1:0]   w_result;

   logic [WIDTH-1:0]     w_hi;
   logic [WIDTH-1:0]     w_lo;
   logic [2*WIDTH-1:0]   w_read_data;

   assign w_op       = op_e'(io_mdu.op);
   assign w_start_ok = io_mdu.start && op_is_valid(io_mdu.op);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_start_ok) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == '0) w_state_next = S_DONE;
         S_DONE:  w_state_next = w_start_ok ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_busy   = 1'b0;
      w_done   = 1'b0;
      w_accept = 1'b0;
      w_last   = 1'b0;
      unique case (r_state)
         S_IDLE: w_accept = w_start_ok;
         S_RUN: begin
            w_busy = 1'b1;
            w_last = (r_cnt == '0);
         end
         S_DONE: begin
            w_done   = 1'b1;
            w_accept = w_start_ok;
         end
         default: ;
      endcase
   end

   assign w_load  = w_last;
   // Direct writes are blocked while computing and lose to a same-edge Start.
   assign w_wr_hi = io_mdu.write_hi && !w_busy && !w_accept;
   assign w_wr_lo = io_mdu.write_lo && !w_busy && !w_accept;

   // ---------------- Datapath: one iteration step ----------------
   assign w_a_abs = (w_op == OP_MUL && io_mdu.a[WIDTH-1]) ? (~io_mdu.a + 1'b1) : io_mdu.a;
   assign w_b_abs = (w_op == OP_MUL && io_mdu.b[WIDTH-1]) ? (~io_mdu.b + 1'b1) : io_mdu.b;

   // Multiplier sits in the low half and shifts out as the partial product shifts in.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

   // Remainder in the high half, dividend/quotient in the low half.
   assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opnd};
   assign w_ge       = ~w_diff[WIDTH+1];
   assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_ge};

   assign w_acc_next = (r_op == OP_DIVU) ? w_div_next : w_mul_next;
   assign w_result   = (r_op == OP_MUL && r_sign) ? (~w_acc_next + 1'b1) : w_acc_next;

   // ---------------- Datapath registers ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_sign <= 1'b0;
         r_op   <= OP_MULU;
      end else if (w_accept) begin
         r_op   <= w_op;
         r_cnt  <= CW'(WIDTH - 1);
         r_sign <= (w_op == OP_MUL) && (io_mdu.a[WIDTH-1] ^ io_mdu.b[WIDTH-1]);
         if (w_op == OP_DIVU) begin
            r_opnd <= io_mdu.b;
            r_acc  <= {{WIDTH{1'b0}}, io_mdu.a};
         end else begin
            r_opnd <= w_a_abs;
            r_acc  <= {{WIDTH{1'b0}}, w_b_abs};
         end
      end else if (w_busy) begin
         r_acc <= w_acc_next;
         if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
   end

   mdu_hilo_reg #(
      .WIDTH(WIDTH)
   ) u_hilo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (w_load),
      .i_result    (w_result),
      .i_wr_hi     (w_wr_hi),
      .i_wr_lo     (w_wr_lo),
      .i_wr_data   (io_mdu.write_data),
      .o_hi        (w_hi),
      .o_lo        (w_lo),
      .o_read_data (w_read_data)
   );

   assign io_mdu.busy      = w_busy;
   assign io_mdu.done      = w_done;
   assign io_mdu.hi        = w_hi;
   assign io_mdu.lo        = w_lo;
   assign io_mdu.read_data = w_read_data;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit (WIDTH=24) plus multi-cycle corner sequences.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int W = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mdu_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_mdu (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [23:0] a;
      logic [23:0] b;
      logic [23:0] hi;
      logic [23:0] lo;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start      = 1'b0;
      bus.op         = 2'b00;
      bus.a          = '0;
      bus.b          = '0;
      bus.write_hi   = 1'b0;
      bus.write_lo   = 1'b0;
      bus.write_data = '0;
   endtask

   // Steps negedges until Done, clearing Start after the first edge; cyc=-1 on timeout.
   task automatic wait_done(output int cyc, output int nbusy);
      cyc   = -1;
      nbusy = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin
            cyc = k;
            check("busy_with_done", 64'(bus.busy), 64'd0);
            break;
         end
         if (bus.busy) nbusy++;
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                         output int cyc, output int nbusy);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      wait_done(cyc, nbusy);
      $display("op=%0d a=%06h b=%06h -> hi=%06h lo=%06h latency=%0d busy=%0d",
               op, a, b, bus.hi, bus.lo, cyc, nbusy);
   endtask

   initial begin
      int  cyc;
      int  nbusy;
      int  cyc2;
      bit  seen_done;

      vecs[0] = '{"mulu_max",   2'b00, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 24'h000001};
      vecs[1] = '{"mul_neg3x5", 2'b01, 24'hFFFFFD, 24'h000005, 24'hFFFFFF, 24'hFFFFF1};
      vecs[2] = '{"mul_minsq",  2'b01, 24'h800000, 24'h800000, 24'h400000, 24'h000000};
      vecs[3] = '{"divu_100_7", 2'b10, 24'd100,    24'd7,      24'h000002, 24'h00000E};
      vecs[4] = '{"divu_by0",   2'b10, 24'h123456, 24'h000000, 24'h123456, 24'hFFFFFF};
      vecs[5] = '{"mulu_small", 2'b00, 24'h000003, 24'h000004, 24'h000000, 24'h00000C};
      vecs[6] = '{"mul_maxneg1",2'b01, 24'h7FFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h800001};
      vecs[7] = '{"divu_big16", 2'b10, 24'hFFFFFF, 24'h000010, 24'h00000F, 24'h0FFFFF};
      vecs[8] = '{"divu_lt",    2'b10, 24'd5,      24'd9,      24'h000005, 24'h000000};

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi",   64'(bus.hi), 64'd0);
      check("rst_lo",   64'(bus.lo), 64'd0);
      check("rst_rd",   64'(bus.read_data), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, nbusy);
         check({vecs[i].name, "_latency"}, 64'(cyc), 64'd25);
         check({vecs[i].name, "_busycyc"}, 64'(nbusy), 64'd24);
         check({vecs[i].name, "_hi"}, 64'(bus.hi), 64'(vecs[i].hi));
         check({vecs[i].name, "_lo"}, 64'(bus.lo), 64'(vecs[i].lo));
         check({vecs[i].name, "_rd"}, 64'(bus.read_data), {16'h0, vecs[i].hi, vecs[i].lo});
         @(negedge clk);
         check({vecs[i].name, "_done_width"}, 64'(bus.done), 64'd0);
      end

      // Start and WriteHi during RUN must be ignored; HI/LO hold the previous result.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 24'd2; bus.b = 24'd3;
      cyc = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         bus.start    = 1'b0;
         bus.write_hi = 1'b0;
         if (bus.done) begin
            cyc = k;
            break;
         end
         if (k == 5) begin
            bus.start = 1'b1; bus.op = 2'b10; bus.a = 24'd100; bus.b = 24'd7;
            bus.write_hi = 1'b1; bus.write_data = 24'hABCDEF;
         end
         if (k == 10) begin
            check("run_hold_hi", 64'(bus.hi), 64'h000005);
            check("run_hold_lo", 64'(bus.lo), 64'h000000);
         end
      end
      $display("op=0 a=000002 b=000003 (start+writehi mid-run) -> hi=%06h lo=%06h latency=%0d",
               bus.hi, bus.lo, cyc);
      check("midrun_latency", 64'(cyc), 64'd25);
      check("midrun_hi", 64'(bus.hi), 64'h0);
      check("midrun_lo", 64'(bus.lo), 64'h6);
      @(negedge clk);
      check("midrun_no_restart", 64'(bus.busy), 64'd0);

      // Direct writes in IDLE.
      bus.write_hi = 1'b1; bus.write_data = 24'hABCDEF;
      @(negedge clk);
      bus.write_hi = 1'b0;
      $display("writehi data=abcdef -> hi=%06h lo=%06h", bus.hi, bus.lo);
      check("wrhi_hi", 64'(bus.hi), 64'hABCDEF);
      check("wrhi_lo", 64'(bus.lo), 64'h6);
      bus.write_lo = 1'b1; bus.write_data = 24'h123123;
      @(negedge clk);
      bus.write_lo = 1'b0;
      $display("writelo data=123123 -> hi=%06h lo=%06h", bus.hi, bus.lo);
      check("wrlo_hi", 64'(bus.hi), 64'hABCDEF);
      check("wrlo_lo", 64'(bus.lo), 64'h123123);
      bus.write_hi = 1'b1; bus.write_lo = 1'b1; bus.write_data = 24'h777777;
      @(negedge clk);
      bus.write_hi = 1'b0; bus.write_lo = 1'b0;
      $display("writehi+lo data=777777 -> hi=%06h lo=%06h", bus.hi, bus.lo);
      check("wrboth_hi", 64'(bus.hi), 64'h777777);
      check("wrboth_lo", 64'(bus.lo), 64'h777777);

      // Start and WriteHi on the same edge: Start wins.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 24'd2; bus.b = 24'd3;
      bus.write_hi = 1'b1; bus.write_data = 24'h555555;
      @(negedge clk);
      bus.start = 1'b0; bus.write_hi = 1'b0;
      check("startwr_hi_kept", 64'(bus.hi), 64'h777777);
      check("startwr_busy", 64'(bus.busy), 64'd1);
      wait_done(cyc, nbusy);
      $display("op=0 a=000002 b=000003 (with same-edge writehi) -> hi=%06h lo=%06h", bus.hi, bus.lo);
      check("startwr_latency", 64'(cyc), 64'd24);
      check("startwr_hi", 64'(bus.hi), 64'h0);
      check("startwr_lo", 64'(bus.lo), 64'h6);
      @(negedge clk);

      // Reserved op is a no-op.
      bus.start = 1'b1; bus.op = 2'b11; bus.a = 24'd9; bus.b = 24'd9;
      @(negedge clk);
      bus.start = 1'b0;
      $display("op=3 (reserved) -> busy=%0d done=%0d", bus.busy, bus.done);
      check("opnone_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      check("opnone_done", 64'(bus.done), 64'd0);

      // Back-to-back: Start held during DONE.
      run_op(2'b00, 24'd3, 24'd4, cyc, nbusy);
      check("b2b_first_latency", 64'(cyc), 64'd25);
      check("b2b_first_lo", 64'(bus.lo), 64'hC);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 24'd100; bus.b = 24'd7;
      @(negedge clk);
      bus.start = 1'b0;
      check("b2b_busy_rise", 64'(bus.busy), 64'd1);
      check("b2b_done_drop", 64'(bus.done), 64'd0);
      wait_done(cyc2, nbusy);
      $display("op=2 a=000064 b=000007 (back-to-back) -> hi=%06h lo=%06h gap=%0d",
               bus.hi, bus.lo, (cyc2 < 0) ? -1 : cyc2 + 1);
      check("b2b_done_gap", 64'((cyc2 < 0) ? -1 : cyc2 + 1), 64'd25);
      check("b2b_hi", 64'(bus.hi), 64'h2);
      check("b2b_lo", 64'(bus.lo), 64'hE);
      @(negedge clk);

      // Reset at RUN cycle 10 aborts the operation.
      bus.start = 1'b1; bus.op = 2'b00; bus.a = 24'hFFFFFF; bus.b = 24'hFFFFFF;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("abort_busy_before", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("reset mid-run -> busy=%0d done=%0d hi=%06h lo=%06h", bus.busy, bus.done, bus.hi, bus.lo);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hi", 64'(bus.hi), 64'd0);
      check("abort_lo", 64'(bus.lo), 64'd0);
      seen_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done = 1'b1;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      check("abort_rd", 64'(bus.read_data), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with an integrated HI/LO result register, parametrised in operand width. It sits beside the ALU in the execute stage. It accepts one operation at a time and computes it over WIDTH iteration cycles, then holds the double-width result for mfhi/mflo-style reads. Direct HI/LO write ports support mthi/mtlo.

## Interface
- WIDTH, 24, operand width; result register is 2*WIDTH bits.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request to begin an operation; sampled on rising edge.
- Op  in  2  operation select: 00 MULU, 01 MUL (signed), 10 DIVU, 11 reserved (treated as no-op, Start ignored).
- A  in  WIDTH  multiplicand / dividend; latched when Start is accepted.
- B  in  WIDTH  multiplier / divisor; latched when Start is accepted.
- WriteHi  in  1  direct write of WriteData into HI.
- WriteLo  in  1  direct write of WriteData into LO.
- WriteData  in  WIDTH  data for direct writes.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; result valid in HI/LO.
- Hi  out  WIDTH  upper half of result register.
- Lo  out  WIDTH  lower half of result register.
- ReadData  out  2*WIDTH  {Hi, Lo}.

## Operation
- States:
  - IDLE: no operation. Start with a valid Op goes to RUN.
  - RUN: runs WIDTH iterations using iteration counter cnt. When cnt==0 at an edge, goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE. Start with a valid Op accepted here goes straight to RUN.
- Start is accepted only in IDLE or DONE. It is ignored in RUN, and ignored for Op=11.
- On accept:
  - latch A and B, set cnt=WIDTH-1, clear the working accumulator.
  - For MUL, latch |A| and |B|, plus sign = A[WIDTH-1]^B[WIDTH-1].
- MULU/MUL use shift-add: one multiplier bit per RUN cycle, 2*WIDTH-bit accumulator.
- MUL: on the final edge, the product is two's-complement negated if sign=1. |−2^(WIDTH−1)| fits unsigned, so there is no overflow case.
- DIVU uses restoring division, one quotient bit per cycle.
  - Result: Lo=quotient, Hi=remainder.
  - Divide by zero is not special-cased. The natural algorithm yields Lo=all ones, Hi=A, with the same latency.
- The result register is written only on the RUN→DONE edge. HI/LO keep their old values throughout RUN.
- Direct writes (WriteHi/WriteLo):
  - Take effect on the edge in IDLE or DONE only. They are ignored in RUN.
  - Ignored on the same edge a Start is accepted; Start has priority.
  - WriteHi and WriteLo together write both halves.
- Reset (synchronous, any state, including mid-RUN):
  - State=IDLE, Busy=0, Done=0, Hi=0, Lo=0, cnt=0. Any in-flight operation is aborted with no result written.

## Timing
- Start accepted at edge E0 → Busy=1 for cycles 1..WIDTH after E0.
- Result written at edge E_WIDTH → Done=1 and new Hi/Lo visible in cycle WIDTH+1 (latency WIDTH+1 cycles; 25 for WIDTH=24).
- Busy and Done are registered, never asserted together. Done is exactly one cycle wide.
- Back-to-back operation: Start held high during DONE begins the next operation immediately. Throughput is one result per WIDTH+1 cycles.
- A direct write is visible on Hi/Lo the cycle after its edge.
- Outputs after reset: Busy=0, Done=0, Hi=0, Lo=0, ReadData=0.

## Structure
- Package mdu_pkg:
  - Op encoding enum (OP_MULU, OP_MUL, OP_DIVU, OP_NONE).
  - State enum (S_IDLE, S_RUN, S_DONE).
- Sub-module mdu_hilo_reg: the 2*WIDTH result register.
  - Synchronous reset.
  - Three write sources with a priority mux: result load > WriteHi/WriteLo.
  - Drives Hi, Lo, ReadData.
- Top level holds the FSM, counter, operand/accumulator datapath and sign fix-up.

## Test plan
- Reset, then MULU A=0xFFFFFF, B=0xFFFFFF → Busy for 24 cycles; Done in cycle 25 after the Start edge; Hi=0xFFFFFE, Lo=0x000001.
- MUL A=0xFFFFFD (−3), B=0x000005 → Hi=0xFFFFFF, Lo=0xFFFFF1. Also MUL A=0x800000, B=0x800000 → Hi=0x400000, Lo=0x000000.
- DIVU A=100, B=7 → Lo=0x00000E, Hi=0x000002. Then DIVU A=0x123456, B=0 → Lo=0xFFFFFF, Hi=0x123456, same latency.
- Start pulsed and WriteHi=1 (WriteData=0xABCDEF) during RUN → both ignored; the original result lands unchanged. WriteHi in IDLE → Hi=0xABCDEF next cycle, Lo unchanged.
- Start held high in the DONE cycle with a new operand pair → Busy rises the next cycle; second Done exactly 25 cycles after the first.
- Reset asserted at RUN cycle 10 → next cycle Busy=0, Done=0, Hi=Lo=0. No Done pulse follows.
